// File: rtl/uart_bus_bridge_if.sv
// Peripheral bus seen from the bridge: strobes, address and write data go out,
// read data comes back from the selected peripheral.
interface uart_bus_bridge_if;
  logic        cs;
  logic        rd;
  logic        wr;
  logic [3:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;

  modport master (output cs, rd, wr, addr, wdata, input rdata);
  modport slave  (input cs, rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_bus_bridge.sv
// UART command bridge: 8N1 packets on ser_rx become single bus reads/writes,
// and the acknowledge or read data is returned on ser_tx.
module uart_bus_bridge #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ser_rx,
  output logic                   ser_tx,
  uart_bus_bridge_if.master      bus,
  output logic                   busy,
  output logic                   err
);

  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TO_LIMIT);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    ST_IDLE, ST_GET_ADDR_W, ST_GET_DHI, ST_GET_DLO, ST_BUS_WR,
    ST_GET_ADDR_R, ST_BUS_RD1, ST_BUS_RD2, ST_SEND
  } state_t;

  logic [1:0]       sync_reg;
  logic             rx_prev_reg;
  rx_state_t        rx_state_reg;
  logic [CNT_W-1:0] rx_cnt_reg;
  logic [2:0]       rx_bit_reg;
  logic [7:0]       rx_shift_reg;
  logic [7:0]       rx_byte_reg;
  logic             rx_valid_reg;
  logic             rx_ferr_reg;

  state_t           state_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic [3:0]       pkt_addr_reg;
  logic [7:0]       pkt_dhi_reg;
  logic             cs_reg, rd_reg, wr_reg;
  logic [3:0]       addr_reg;
  logic [15:0]      wdata_reg;
  logic             err_reg;
  logic             ser_tx_reg;
  logic [15:0]      tx_q_reg;      // response bytes, next one in [15:8]
  logic [1:0]       tx_left_reg;
  logic             tx_active_reg;
  logic [CNT_W-1:0] tx_cnt_reg;
  logic [3:0]       tx_bit_reg;
  logic [8:0]       tx_shift_reg;
  logic             discard_phase;

  assign bus.cs    = cs_reg;
  assign bus.rd    = rd_reg;
  assign bus.wr    = wr_reg;
  assign bus.addr  = addr_reg;
  assign bus.wdata = wdata_reg;
  assign ser_tx    = ser_tx_reg;
  assign err       = err_reg;
  assign busy      = (state_reg != ST_IDLE);
  // Bytes landing while a bus cycle or response is in flight are thrown away.
  assign discard_phase = state_reg inside {ST_BUS_WR, ST_BUS_RD1, ST_BUS_RD2, ST_SEND};

  // Bring ser_rx into the clock domain; reset to idle-high so no false start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_reg <= 2'b11;
    else      sync_reg <= {sync_reg[0], ser_rx};
  end

  // Receiver: falling edge, mid-bit start re-check, 8 data bits LSB first, stop check.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_byte_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_prev_reg  <= sync_reg[1];
      rx_valid_reg <= 1'b0;
      rx_ferr_reg  <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          rx_cnt_reg <= '0;
          if (rx_prev_reg && !sync_reg[1]) rx_state_reg <= RX_START;
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_state_reg <= sync_reg[1] ? RX_IDLE : RX_DATA;  // high here = glitch
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {sync_reg[1], rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 3'd1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
          end
        end
        default: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_IDLE;
            if (sync_reg[1]) begin
              rx_byte_reg  <= rx_shift_reg;
              rx_valid_reg <= 1'b1;
            end else begin
              rx_ferr_reg  <= 1'b1;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Command FSM with bus strobes and the response transmitter, all registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      to_cnt_reg    <= '0;
      pkt_addr_reg  <= '0;
      pkt_dhi_reg   <= '0;
      cs_reg        <= 1'b0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      err_reg       <= 1'b0;
      ser_tx_reg    <= 1'b1;
      tx_q_reg      <= '0;
      tx_left_reg   <= '0;
      tx_active_reg <= 1'b0;
      tx_cnt_reg    <= '0;
      tx_bit_reg    <= '0;
      tx_shift_reg  <= '1;
    end else begin
      err_reg <= rx_ferr_reg;
      case (state_reg)
        ST_IDLE: begin
          to_cnt_reg <= '0;
          if (rx_valid_reg) begin
            if (rx_byte_reg == 8'h57) begin
              state_reg <= ST_GET_ADDR_W;
            end else if (rx_byte_reg == 8'h52) begin
              state_reg <= ST_GET_ADDR_R;
            end else begin
              tx_q_reg    <= {8'h3F, 8'h00};
              tx_left_reg <= 2'd1;
              err_reg     <= 1'b1;
              state_reg   <= ST_SEND;
            end
          end
        end
        ST_GET_ADDR_W, ST_GET_DHI, ST_GET_DLO, ST_GET_ADDR_R: begin
          to_cnt_reg <= to_cnt_reg + TO_W'(1);
          if (rx_valid_reg) begin
            to_cnt_reg <= '0;
            case (state_reg)
              ST_GET_ADDR_W: begin
                pkt_addr_reg <= rx_byte_reg[3:0];
                state_reg    <= ST_GET_DHI;
              end
              ST_GET_DHI: begin
                pkt_dhi_reg <= rx_byte_reg;
                state_reg   <= ST_GET_DLO;
              end
              ST_GET_DLO: begin
                addr_reg  <= pkt_addr_reg;
                wdata_reg <= {pkt_dhi_reg, rx_byte_reg};
                cs_reg    <= 1'b1;
                wr_reg    <= 1'b1;
                state_reg <= ST_BUS_WR;
              end
              default: begin
                addr_reg  <= rx_byte_reg[3:0];
                cs_reg    <= 1'b1;
                rd_reg    <= 1'b1;
                state_reg <= ST_BUS_RD1;
              end
            endcase
          end else if (rx_ferr_reg || to_cnt_reg == TO_MAX) begin
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        ST_BUS_WR: begin
          cs_reg      <= 1'b0;
          wr_reg      <= 1'b0;
          tx_q_reg    <= {8'h4B, 8'h00};
          tx_left_reg <= 2'd1;
          state_reg   <= ST_SEND;
        end
        ST_BUS_RD1: state_reg <= ST_BUS_RD2;
        ST_BUS_RD2: begin
          cs_reg      <= 1'b0;
          rd_reg      <= 1'b0;
          tx_q_reg    <= bus.rdata;   // doubles as the read-data holding register
          tx_left_reg <= 2'd2;
          state_reg   <= ST_SEND;
        end
        ST_SEND: begin
          if (!tx_active_reg || (tx_cnt_reg == BIT_LAST && tx_bit_reg == 4'd9)) begin
            if (tx_active_reg && tx_left_reg == 2'd0) begin
              tx_active_reg <= 1'b0;
              state_reg     <= ST_IDLE;
            end else begin
              // Start bit of the next queued byte, straight after the previous stop bit.
              ser_tx_reg    <= 1'b0;
              tx_shift_reg  <= {1'b1, tx_q_reg[15:8]};
              tx_q_reg      <= {tx_q_reg[7:0], 8'h00};
              tx_left_reg   <= tx_left_reg - 2'd1;
              tx_active_reg <= 1'b1;
              tx_cnt_reg    <= '0;
              tx_bit_reg    <= '0;
            end
          end else if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            ser_tx_reg   <= tx_shift_reg[0];
            tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
            tx_bit_reg   <= tx_bit_reg + 4'd1;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (rx_valid_reg && discard_phase) err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: drives serial packets, scoreboards bus cycles and
// serial responses against queues filled when each packet is sent.
module tb_uart_bus_bridge;
  localparam int CPB = 16;
  localparam int TOB = 20;

  typedef struct {
    bit          is_wr;
    logic [3:0]  addr;
    logic [15:0] data;
  } bus_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ser_rx = 1'b1;
  logic ser_tx, busy, err;

  uart_bus_bridge_if bus_if ();

  uart_bus_bridge #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk    (clk),
    .rst    (rst),
    .ser_rx (ser_rx),
    .ser_tx (ser_tx),
    .bus    (bus_if),
    .busy   (busy),
    .err    (err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int err_cnt = 0;
  int last_start = 0;
  int prev_start = 0;
  bit tx_ignore = 0;
  logic [7:0] tx_q[$];
  bus_exp_t bus_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (err) err_cnt <= err_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      ser_rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    ser_rx = 1'b1;
    $display("[TB] sent byte 0x%02h stop=%0b", b, stop_bit);
  endtask

  task automatic push_bus(input bit is_wr, input logic [3:0] addr, input logic [15:0] data);
    bus_exp_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.data  = data;
    bus_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 32'(n < 3000), 32'd1);
    check({tag, "_busq"}, 32'(bus_q.size()), 32'd0);
  endtask

  // Bus monitor: pop one expectation at each strobe start, check its length at the end.
  initial begin
    bit active;
    bit cur_wr;
    int len;
    bus_exp_t e;
    active = 0;
    cur_wr = 0;
    len = 0;
    forever begin
      @(negedge clk);
      if (bus_if.cs && (bus_if.rd || bus_if.wr)) begin
        if (!active) begin
          active = 1;
          len = 0;
          cur_wr = bus_if.wr;
          $display("[TB] bus %s addr=%0h wdata=%04h", cur_wr ? "WR" : "RD", bus_if.addr, bus_if.wdata);
          if (bus_q.size() == 0) begin
            check("bus_unexpected", 32'(bus_q.size()), 32'd1);
          end else begin
            e = bus_q.pop_front();
            check("bus_kind", 32'(bus_if.wr), 32'(e.is_wr));
            check("bus_addr", 32'(bus_if.addr), 32'(e.addr));
            if (e.is_wr) check("bus_wdata", 32'(bus_if.wdata), 32'(e.data));
          end
        end
        len++;
      end else if (active) begin
        active = 0;
        if (cur_wr) check("wr_len", 32'(len), 32'd1);
        else        check("rd_len", 32'(len), 32'd2);
      end
    end
  end

  // Serial monitor: decode ser_tx frames at mid-bit and compare with the queue.
  initial begin
    logic [7:0] b;
    logic stopb;
    logic prev;
    prev = 1'b1;
    b = '0;
    forever begin
      @(negedge clk);
      if (prev && !ser_tx) begin
        prev_start = last_start;
        last_start = cyc;
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = ser_tx;
        end
        repeat (CPB) @(negedge clk);
        stopb = ser_tx;
        $display("[TB] tx byte 0x%02h stop=%0b%s", b, stopb, tx_ignore ? " (ignored)" : "");
        if (!tx_ignore) begin
          check("tx_stop", 32'(stopb), 32'd1);
          if (tx_q.size() == 0) check("tx_unexpected", 32'(tx_q.size()), 32'd1);
          else check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
        end
        prev = stopb;
      end else begin
        prev = ser_tx;
      end
    end
  end

  initial begin
    int e0;
    int n;
    bus_if.rdata = 16'h0000;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ser_tx", 32'(ser_tx), 32'd1);
    check("rst_cs", 32'(bus_if.cs), 32'd0);
    check("rst_rd_wr", 32'({bus_if.rd, bus_if.wr}), 32'd0);
    check("rst_addr", 32'(bus_if.addr), 32'd0);
    check("rst_wdata", 32'(bus_if.wdata), 32'd0);
    check("rst_busy_err", 32'({busy, err}), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Write 57 03 12 34
    e0 = err_cnt;
    push_bus(1, 4'h3, 16'h1234);
    tx_q.push_back(8'h4B);
    send_byte(8'h57, 1); send_byte(8'h03, 1); send_byte(8'h12, 1); send_byte(8'h34, 1);
    wait_done("write");
    check("write_err", 32'(err_cnt - e0), 32'd0);

    // Read 52 02 -> A5 5A back to back
    e0 = err_cnt;
    bus_if.rdata = 16'hA55A;
    push_bus(0, 4'h2, 16'h0);
    tx_q.push_back(8'hA5); tx_q.push_back(8'h5A);
    send_byte(8'h52, 1); send_byte(8'h02, 1);
    wait_done("read");
    check("read_b2b_gap", 32'(last_start - prev_start), 32'(10 * CPB));
    check("read_err", 32'(err_cnt - e0), 32'd0);

    // Unknown command
    e0 = err_cnt;
    tx_q.push_back(8'h3F);
    send_byte(8'h41, 1);
    wait_done("unknown");
    check("unknown_err", 32'(err_cnt - e0), 32'd1);

    // Inter-byte timeout, then a normal read
    e0 = err_cnt;
    send_byte(8'h57, 1); send_byte(8'h05, 1);
    repeat (25 * CPB) @(negedge clk);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    bus_if.rdata = 16'hBEEF;
    push_bus(0, 4'h5, 16'h0);
    tx_q.push_back(8'hBE); tx_q.push_back(8'hEF);
    send_byte(8'h52, 1); send_byte(8'h05, 1);
    wait_done("after_timeout");
    check("after_timeout_err", 32'(err_cnt - e0), 32'd1);

    // Framing error, then a valid write
    e0 = err_cnt;
    send_byte(8'h57, 0);
    repeat (CPB) @(negedge clk);
    check("frame_err", 32'(err_cnt - e0), 32'd1);
    check("frame_busy", 32'(busy), 32'd0);
    push_bus(1, 4'hA, 16'hC0DE);
    tx_q.push_back(8'h4B);
    send_byte(8'h57, 1); send_byte(8'h0A, 1); send_byte(8'hC0, 1); send_byte(8'hDE, 1);
    wait_done("after_frame");
    check("after_frame_err", 32'(err_cnt - e0), 32'd1);

    // Reset in the middle of the 0xA5 response byte
    tx_ignore = 1;
    bus_if.rdata = 16'hA55A;
    push_bus(0, 4'h2, 16'h0);
    send_byte(8'h52, 1); send_byte(8'h02, 1);
    n = 0;
    while (ser_tx && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_tx_started", 32'(n < 2000), 32'd1);
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_ser_tx", 32'(ser_tx), 32'd1);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_strobes", 32'({bus_if.cs, bus_if.rd, bus_if.wr}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    tx_ignore = 0;
    check("rst_mid_ser_tx_idle", 32'(ser_tx), 32'd1);

    // Read after reset; upper address nibble ignored
    bus_if.rdata = 16'h1357;
    push_bus(0, 4'h6, 16'h0);
    tx_q.push_back(8'h13); tx_q.push_back(8'h57);
    send_byte(8'h52, 1); send_byte(8'hF6, 1);
    wait_done("after_rst");
    check("after_rst_b2b_gap", 32'(last_start - prev_start), 32'(10 * CPB));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
